gauss_window_feeder: RTL

Streaming 11-tap window generator that drives the 1-D Gaussian dot-product stage (`gauss_kernel_dotprod`). It accepts one 8-bit pixel per cycle over a valid/ready stream, maintains the sliding 11-pixel neighbourhood of each pixel with edge padding at row boundaries, and presents one full window, together with the row's sigma, per input pixel. Its window output connects directly to the dot-product `din[10:0]` and `sigma` inputs.

---
 rtl/gauss_window_feeder_pkg.sv | 19 +
 rtl/gauss_window_feeder_if.sv | 30 +++
 rtl/gauss_window_feeder_tap_shiftreg.sv | 29 ++
 rtl/gauss_window_feeder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gauss_window_feeder_pkg.sv
// Shared types for the Gaussian window feeder.
// Pixel/window types, tap geometry and FSM states.
package gauss_pkg;
  localparam int DATA_W = 8;
  localparam int TAPS   = 11;
  localparam int HALF   = TAPS / 2;
  localparam int CNT_W  = $clog2(HALF + 2);

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t window_t [TAPS-1:0];
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;
endpackage

// File: rtl/gauss_window_feeder_if.sv
// Pixel-in / window-out stream bundle.
// slave: feeder side; master: source/sink side.
interface gauss_window_feeder_if;
  import gauss_pkg::*;

  logic       s_valid;
  logic       s_ready;
  pixel_t     s_data;
  logic       s_last;
  logic [2:0] sigma_in;
  logic       m_valid;
  logic       m_ready;
  window_t    m_window;
  logic [2:0] m_sigma;
  logic       m_last;

  modport slave (
    input  s_valid, s_data, s_last,
    input  sigma_in, m_ready,
    output s_ready, m_valid, m_window,
    output m_sigma, m_last
  );

  modport master (
    output s_valid, s_data, s_last,
    output sigma_in, m_ready,
    input  s_ready, m_valid, m_window,
    input  m_sigma, m_last
  );
endinterface

// File: rtl/gauss_window_feeder_tap_shiftreg.sv
// 11-tap window register: load fills taps, shift moves toward [0].
// Ports: clk, rst_n, load, shift, fill, head, shift_in, taps.
module gauss_tap_shiftreg
  import gauss_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    shift,
  input  pixel_t  fill,
  input  pixel_t  head,
  input  pixel_t  shift_in,
  output window_t taps
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++)
        taps[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < TAPS-1; i++)
        taps[i] <= fill;
      taps[TAPS-1] <= head;
    end else if (shift) begin
      for (int i = 0; i < TAPS-1; i++)
        taps[i] <= taps[i+1];
      taps[TAPS-1] <= shift_in;
    end
  end
endmodule

// File: rtl/gauss_window_feeder.sv
// Sliding 11-pixel window generator with row-edge padding.
// Ports: clk, rst_n, bus (slave). Macro: GAUSS_WIN_ZERO_PAD_EN.
module gauss_window_feeder
  import gauss_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  gauss_window_feeder_if.slave bus
);
  state_t     state, state_n;
  cnt_t       sc, sc_n, sc_inc;
  cnt_t       lag, lag_n;
  logic [2:0] sigma, sigma_n;
  logic       mv, mv_n;
  logic       ml, ml_n;
  logic       free, acc;
  logic       load, shift, emit, done;
  pixel_t     fill, pad, shift_in;
  window_t    taps;

  assign free   = !mv || bus.m_ready;
  assign bus.s_ready =
    free && (state != FLUSH) && rst_n;
  assign acc    = bus.s_valid && bus.s_ready;
  assign sc_inc = (sc == cnt_t'(HALF)) ?
                  sc : sc + cnt_t'(1);

`ifdef GAUSS_WIN_ZERO_PAD_EN
  assign fill = '0;
  assign pad  = '0;
`else
  assign fill = bus.s_data;
  assign pad  = taps[TAPS-1];
`endif

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    lag_n    = lag;
    sigma_n  = sigma;
    mv_n     = mv;
    ml_n     = ml;
    load     = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;
    done     = 1'b0;
    shift_in = bus.s_data;
    unique case (state)
      IDLE: if (acc) begin
        load    = 1'b1;
        sigma_n = bus.sigma_in;
        sc_n    = '0;
        lag_n   = cnt_t'(1);
        state_n = bus.s_last ? FLUSH : FILL;
      end
      FILL, RUN: if (acc) begin
        shift = 1'b1;
        lag_n = lag + cnt_t'(1);
        if (bus.s_last)
          state_n = FLUSH;
        else if (sc_inc == cnt_t'(HALF))
          state_n = RUN;
      end
      FLUSH: if (free) begin
        shift    = 1'b1;
        shift_in = pad;
      end
      default: state_n = IDLE;
    endcase
    // A window leaves whenever the centre
    // has reached tap HALF after a shift.
    if (shift) begin
      sc_n = sc_inc;
      emit = (sc_inc == cnt_t'(HALF));
      if (emit)
        lag_n = lag_n - cnt_t'(1);
    end
    done = emit && (state == FLUSH) &&
           (lag_n == '0);
    if (free) begin
      mv_n = emit;
      ml_n = done;
    end
    if (done)
      state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sc    <= '0;
      lag   <= '0;
      sigma <= '0;
      mv    <= 1'b0;
      ml    <= 1'b0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      lag   <= lag_n;
      sigma <= sigma_n;
      mv    <= mv_n;
      ml    <= ml_n;
    end
  end

  gauss_tap_shiftreg u_taps (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .fill     (fill),
    .head     (bus.s_data),
    .shift_in (shift_in),
    .taps     (taps)
  );

  assign bus.m_window = taps;
  assign bus.m_valid  = mv;
  assign bus.m_last   = ml;
  assign bus.m_sigma  = sigma;
endmodule
